// File: rtl/decode_if.sv
// Fetch-side handshake and decoded-instruction bundle of the decode stage.
// master = decode stage (drives in_ready and decoded fields), slave = fetch/execute side.
interface decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  cond;
    logic [1:0]  cls;
    logic [3:0]  alu_op;
    logic        set_flags;
    logic        use_imm;
    logic [31:0] imm32;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amt;
    logic [3:0]  rd_addr;
    logic        mem_load;
    logic        mem_store;
    logic        branch;
    logic        link;

    modport master (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, cond, cls, alu_op, set_flags, use_imm, imm32,
               shift_type, shift_amt, rd_addr, mem_load, mem_store, branch, link
    );

    modport slave (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, cond, cls, alu_op, set_flags, use_imm, imm32,
               shift_type, shift_amt, rd_addr, mem_load, mem_store, branch, link
    );
endinterface

// File: rtl/decode_stage.sv
// ARM decode stage: latches one instruction, holds reg_file read addresses/rpc until execute consumes.
// Latency 2 cycles accept->out_valid (+1 per READ cycle with wb_we); macro DECODE_ROT_IMM_EN enables imm rotation.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        wb_we,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    output logic [31:0] rpc,
    decode_if.master    dif
);
    typedef enum logic [1:0] {IDLE, READ, VALID} state_t;

    state_t      state_q;
    logic [31:0] instr_q;
    logic [31:0] rpc_q;
    logic        accept;
    logic [31:0] dp_imm;

    assign dif.in_ready  = reset & ((state_q == IDLE) | ((state_q == VALID) & dif.out_ready));
    assign accept        = dif.in_ready & dif.in_valid & ~flush;
    assign dif.out_valid = (state_q == VALID);
    assign rpc           = rpc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            instr_q <= 32'd0;
            rpc_q   <= 32'd0;
        end else if (flush) begin
            state_q <= IDLE;
        end else if (accept) begin
            instr_q <= dif.in_instr;
            rpc_q   <= dif.in_pc + 32'd8;
            state_q <= READ;
        end else begin
            case (state_q)
                READ:    if (!wb_we) state_q <= VALID;
                VALID:   if (dif.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DECODE_ROT_IMM_EN
    logic [63:0] rot_w;
    assign rot_w  = {24'd0, instr_q[7:0], 24'd0, instr_q[7:0]} >> {instr_q[11:8], 1'b0};
    assign dp_imm = rot_w[31:0];
`else
    assign dp_imm = {24'd0, instr_q[7:0]};
`endif

    always_comb begin
        ra1            = 4'd0;
        ra2            = 4'd0;
        dif.cond       = instr_q[31:28];
        dif.cls        = instr_q[27:26];
        dif.rd_addr    = instr_q[15:12];
        dif.alu_op     = 4'd0;
        dif.set_flags  = 1'b0;
        dif.use_imm    = 1'b0;
        dif.imm32      = 32'd0;
        dif.shift_type = 2'd0;
        dif.shift_amt  = 5'd0;
        dif.mem_load   = 1'b0;
        dif.mem_store  = 1'b0;
        dif.branch     = 1'b0;
        dif.link       = 1'b0;
        case (instr_q[27:26])
            2'b00: begin
                ra1           = instr_q[19:16];
                dif.alu_op    = instr_q[24:21];
                dif.set_flags = instr_q[20];
                dif.use_imm   = instr_q[25];
                if (instr_q[25]) begin
                    dif.imm32 = dp_imm;
                end else begin
                    ra2            = instr_q[3:0];
                    dif.shift_type = instr_q[6:5];
                    dif.shift_amt  = instr_q[11:7];
                end
            end
            2'b01: begin
                ra1           = instr_q[19:16];
                ra2           = instr_q[15:12];
                dif.alu_op    = instr_q[23] ? 4'd4 : 4'd2;
                dif.use_imm   = 1'b1;
                dif.imm32     = {20'd0, instr_q[11:0]};
                dif.mem_load  = instr_q[20];
                dif.mem_store = ~instr_q[20];
            end
            2'b10: begin
                ra1         = 4'd15;
                ra2         = 4'd15;
                dif.use_imm = 1'b1;
                dif.imm32   = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
                dif.branch  = 1'b1;
                dif.link    = instr_q[24];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        wb_we;
    logic [3:0]  ra1, ra2;
    logic [31:0] rpc;
    int          checks = 0;
    int          errors = 0;

    decode_if dif();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .wb_we (wb_we),
        .ra1   (ra1),
        .ra2   (ra2),
        .rpc   (rpc),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  cond;
        logic [1:0]  cls;
        logic [3:0]  alu_op;
        logic        set_flags;
        logic        use_imm;
        logic [31:0] imm32;
        logic [1:0]  shift_type;
        logic [4:0]  shift_amt;
        logic [3:0]  rd_addr;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [31:0] rpc;
        logic        ld;
        logic        st;
        logic        br;
        logic        lk;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fields(input vec_t v, input int idx);
        chk($sformatf("v%0d cond", idx),       dif.cond,       v.cond);
        chk($sformatf("v%0d cls", idx),        dif.cls,        v.cls);
        chk($sformatf("v%0d alu_op", idx),     dif.alu_op,     v.alu_op);
        chk($sformatf("v%0d set_flags", idx),  dif.set_flags,  v.set_flags);
        chk($sformatf("v%0d use_imm", idx),    dif.use_imm,    v.use_imm);
        chk($sformatf("v%0d imm32", idx),      dif.imm32,      v.imm32);
        chk($sformatf("v%0d shift_type", idx), dif.shift_type, v.shift_type);
        chk($sformatf("v%0d shift_amt", idx),  dif.shift_amt,  v.shift_amt);
        chk($sformatf("v%0d rd_addr", idx),    dif.rd_addr,    v.rd_addr);
        chk($sformatf("v%0d ra1", idx),        ra1,            v.ra1);
        chk($sformatf("v%0d ra2", idx),        ra2,            v.ra2);
        chk($sformatf("v%0d rpc", idx),        rpc,            v.rpc);
        chk($sformatf("v%0d flags", idx),
            {dif.mem_load, dif.mem_store, dif.branch, dif.link},
            {v.ld, v.st, v.br, v.lk});
    endtask

    // Offer an instruction from IDLE and return right after the accepting edge.
    task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input string nm);
        dif.in_valid = 1'b1;
        dif.in_instr = instr;
        dif.in_pc    = pc;
        chk({nm, " in_ready"}, dif.in_ready, 1'b1);
        tick();
        dif.in_valid = 1'b0;
        dif.in_instr = 32'hDEAD_BEEF;
        dif.in_pc    = 32'hDEAD_BEEF;
    endtask

    initial begin
        logic [31:0] mov_imm, rot1_imm;
`ifdef DECODE_ROT_IMM_EN
        mov_imm  = 32'h3F00_0000;
        rot1_imm = 32'h8000_0000;
`else
        mov_imm  = 32'h0000_003F;
        rot1_imm = 32'h0000_0002;
`endif
        //          instr         pc            cnd  cls alu  S  I  imm32         st sa  rd   ra1  ra2  rpc           ld st br lk
        vecs[0] = '{32'hE28210FF, 32'h0000_0000, 4'hE, 2'd0, 4'd4, 1'b0, 1'b1, 32'h0000_00FF, 2'd0, 5'd0, 4'd1, 4'd2, 4'd0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hE3A0043F, 32'h0000_0200, 4'hE, 2'd0, 4'd13, 1'b0, 1'b1, mov_imm, 2'd0, 5'd0, 4'd0, 4'd0, 4'd0, 32'h0000_0208, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'hE3A00102, 32'h0000_0210, 4'hE, 2'd0, 4'd13, 1'b0, 1'b1, rot1_imm, 2'd0, 5'd0, 4'd0, 4'd0, 4'd0, 32'h0000_0218, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'hE5843008, 32'h0000_0300, 4'hE, 2'd1, 4'd4, 1'b0, 1'b1, 32'h0000_0008, 2'd0, 5'd0, 4'd3, 4'd4, 4'd3, 32'h0000_0308, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'hEAFFFFFE, 32'h0000_0100, 4'hE, 2'd2, 4'd0, 1'b0, 1'b1, 32'hFFFF_FFF8, 2'd0, 5'd0, 4'hF, 4'd15, 4'd15, 32'h0000_0108, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'hE05651A7, 32'h0000_0400, 4'hE, 2'd0, 4'd2, 1'b1, 1'b0, 32'h0000_0000, 2'd1, 5'd3, 4'd5, 4'd6, 4'd7, 32'h0000_0408, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'hE5121004, 32'h0000_0500, 4'hE, 2'd1, 4'd2, 1'b0, 1'b1, 32'h0000_0004, 2'd0, 5'd0, 4'd1, 4'd2, 4'd1, 32'h0000_0508, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hEB000010, 32'h0000_0600, 4'hE, 2'd2, 4'd0, 1'b0, 1'b1, 32'h0000_0040, 2'd0, 5'd0, 4'd0, 4'd15, 4'd15, 32'h0000_0608, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{32'h5C123456, 32'hFFFF_FFF8, 4'h5, 2'd3, 4'd0, 1'b0, 1'b0, 32'h0000_0000, 2'd0, 5'd0, 4'd3, 4'd0, 4'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b0; flush = 1'b0; wb_we = 1'b0;
        dif.in_valid = 1'b0; dif.out_ready = 1'b0;
        dif.in_instr = 32'hFFFF_FFFF; dif.in_pc = 32'hFFFF_FFFF;
        tick(); tick();
        chk("reset in_ready",  dif.in_ready,  1'b0);
        chk("reset out_valid", dif.out_valid, 1'b0);
        chk("reset ra",        {ra1, ra2},    8'h00);
        chk("reset rpc",       rpc,           32'h0);
        chk("reset imm32",     dif.imm32,     32'h0);
        reset = 1'b1;
        #1;
        chk("post-reset in_ready", dif.in_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            offer(vecs[i].instr, vecs[i].pc, $sformatf("v%0d", i));
            chk($sformatf("v%0d READ out_valid", i), dif.out_valid, 1'b0);
            chk($sformatf("v%0d READ ra", i), {ra1, ra2}, {vecs[i].ra1, vecs[i].ra2});
            tick();
            chk($sformatf("v%0d out_valid", i), dif.out_valid, 1'b1);
            check_fields(vecs[i], i);
            tick();
            chk($sformatf("v%0d hold out_valid", i), dif.out_valid, 1'b1);
            chk($sformatf("v%0d hold in_ready", i), dif.in_ready, 1'b0);
            dif.out_ready = 1'b1;
            tick();
            dif.out_ready = 1'b0;
            chk($sformatf("v%0d drain out_valid", i), dif.out_valid, 1'b0);
        end

        // Write-port stall: two READ cycles with wb_we held high.
        offer(32'hE5843008, 32'h0000_0300, "stall");
        wb_we = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("stall%0d out_valid", k), dif.out_valid, 1'b0);
            chk($sformatf("stall%0d ra", k), {ra1, ra2}, 8'h43);
        end
        wb_we = 1'b0;
        tick();
        chk("stall out_valid", dif.out_valid, 1'b1);
        chk("stall ra", {ra1, ra2}, 8'h43);

        // Back-to-back accept from VALID.
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_instr  = 32'hE28210FF;
        dif.in_pc     = 32'h0000_0700;
        #1;
        chk("b2b in_ready", dif.in_ready, 1'b1);
        tick();
        dif.in_valid = 1'b0;
        dif.out_ready = 1'b0;
        chk("b2b READ out_valid", dif.out_valid, 1'b0);
        tick();
        chk("b2b out_valid", dif.out_valid, 1'b1);
        chk("b2b ra1", ra1, 4'd2);
        chk("b2b rpc", rpc, 32'h0000_0708);

        // Flush in VALID with out_ready and a new instruction offered: nothing accepted.
        flush = 1'b1;
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_instr  = 32'hEAFFFFFE;
        dif.in_pc     = 32'h0000_0900;
        tick();
        flush = 1'b0;
        dif.in_valid = 1'b0;
        dif.out_ready = 1'b0;
        chk("flush out_valid", dif.out_valid, 1'b0);
        chk("flush in_ready",  dif.in_ready,  1'b1);
        chk("flush rpc kept",  rpc,           32'h0000_0708);
        tick(); tick();
        chk("flush no accept", dif.out_valid, 1'b0);

        // Reset mid-READ drops the instruction.
        offer(32'hEAFFFFFE, 32'h0000_0100, "rst");
        reset = 1'b0;
        tick();
        chk("midrst out_valid", dif.out_valid, 1'b0);
        chk("midrst in_ready",  dif.in_ready,  1'b0);
        chk("midrst ra",        {ra1, ra2},    8'h00);
        chk("midrst rpc",       rpc,           32'h0);
        chk("midrst imm32",     dif.imm32,     32'h0);
        chk("midrst cls/br",    {dif.cls, dif.branch, dif.use_imm}, 4'h0);
        reset = 1'b1;
        tick(); tick();
        chk("midrst stays idle", dif.out_valid, 1'b0);
        chk("midrst in_ready after", dif.in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
